// File: rtl/mips_mc_controller_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, FSM state encoding,
// ALU/PC/source-B mux selects and the beat-counter width helper.
package mips_mc_controller_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_LBRD   = 4'd4,
      S_LBWR   = 4'd5,
      S_SBWR   = 4'd6,
      S_RTEX   = 4'd7,
      S_RTWR   = 4'd8,
      S_BEQEX  = 4'd9,
      S_BNEEX  = 4'd10,
      S_JEX    = 4'd11,
      S_ADDIEX = 4'd12,
      S_ADDIWR = 4'd13,
      S_ILL    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_ONE   = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // A single-beat fetch still needs a one-bit counter.
   function automatic int beat_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
// irwrite carries one lane enable per fetch beat (32/WIDTH lanes).
interface mips_mc_controller_if #(parameter int WIDTH = 8);
   localparam int BEATS = 32 / WIDTH;

   logic [5:0]       op;
   logic             zero;
   logic             mem_ready;
   logic             memread;
   logic             memwrite;
   logic             alusrca;
   logic [1:0]       alusrcb;
   logic [1:0]       aluop;
   logic [1:0]       pcsource;
   logic             iord;
   logic             memtoreg;
   logic             regwrite;
   logic             regdst;
   logic [BEATS-1:0] irwrite;
   logic             pcen;
   logic             illegal;

   modport master (
      input  op, zero, mem_ready,
      output memread, memwrite, alusrca, alusrcb, aluop, pcsource, iord,
             memtoreg, regwrite, regdst, irwrite, pcen, illegal
   );

   modport slave (
      output op, zero, mem_ready,
      input  memread, memwrite, alusrca, alusrcb, aluop, pcsource, iord,
             memtoreg, regwrite, regdst, irwrite, pcen, illegal
   );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM; fetch takes 32/WIDTH beats, each gated by mem_ready.
// Memory states (FETCH/LBRD/SBWR) hold until mem_ready; all other states ignore it.
module mips_mc_controller
   import mips_mc_controller_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   mips_mc_controller_if.master bus
);
   localparam int BEATS = 32 / WIDTH;
   localparam int BW    = beat_w(BEATS);

   state_t        state, state_nxt;
   logic [BW-1:0] beat, beat_nxt;
   logic          last_beat;

   assign last_beat = (beat == BW'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         beat  <= '0;
      end else begin
         state <= state_nxt;
         beat  <= beat_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      unique case (state)
         S_IDLE:   state_nxt = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready) begin
               if (last_beat) begin
                  beat_nxt  = '0;
                  state_nxt = S_DECODE;
               end else begin
                  beat_nxt = beat + BW'(1);
               end
            end
         end
         S_DECODE: begin
            unique case (bus.op)
               OP_LB, OP_SB: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_RTEX;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_BNE:       state_nxt = S_BNEEX;
               OP_J:         state_nxt = S_JEX;
               OP_ADDI:      state_nxt = S_ADDIEX;
               default:      state_nxt = S_ILL;
            endcase
         end
         S_MEMADR: state_nxt = (bus.op == OP_SB) ? S_SBWR : S_LBRD;
         S_LBRD:   if (bus.mem_ready) state_nxt = S_LBWR;
         S_SBWR:   if (bus.mem_ready) state_nxt = S_FETCH;
         S_RTEX:   state_nxt = S_RTWR;
         S_ADDIEX: state_nxt = S_ADDIWR;
         S_LBWR, S_RTWR, S_BEQEX, S_BNEEX, S_JEX, S_ADDIWR, S_ILL:
                   state_nxt = S_FETCH;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.memread  = 1'b0;
      bus.memwrite = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = SRCB_REGB;
      bus.aluop    = ALUOP_ADD;
      bus.pcsource = PCSRC_ALU;
      bus.iord     = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regwrite = 1'b0;
      bus.regdst   = 1'b0;
      bus.irwrite  = '0;
      bus.pcen     = 1'b0;
      bus.illegal  = 1'b0;
      unique case (state)
         S_FETCH: begin
            bus.memread = 1'b1;
            bus.alusrcb = SRCB_ONE;
            if (bus.mem_ready) begin
               bus.irwrite = BEATS'(1) << beat;
               bus.pcen    = 1'b1;
            end
         end
         S_DECODE: bus.alusrcb = SRCB_IMMSH;
         S_MEMADR, S_ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
         end
         S_LBRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
         end
         S_LBWR: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
         end
         S_SBWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
         end
         S_RTEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_FUNCT;
         end
         S_RTWR: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
         end
         // Branch target was parked in ALUOut during DECODE; the compare runs now.
         S_BEQEX, S_BNEEX: begin
            bus.alusrca  = 1'b1;
            bus.aluop    = ALUOP_SUB;
            bus.pcsource = PCSRC_ALUOUT;
            bus.pcen     = (state == S_BEQEX) ? bus.zero : ~bus.zero;
         end
         S_JEX: begin
            bus.pcsource = PCSRC_JUMP;
            bus.pcen     = 1'b1;
         end
         S_ADDIWR: bus.regwrite = 1'b1;
         S_ILL:    bus.illegal  = 1'b1;
         default: ;
      endcase
   end

endmodule
